// File: rtl/bomb_pkg.sv
// Shared state/display types, key and segment constants, and the decode/BCD
// helpers used by the bomb_lock countdown lock.
package bomb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_DEFUSED,
        ST_EXPLODED
    } state_t;

    typedef enum logic [1:0] {
        DISP_DIGIT,
        DISP_DASH,
        DISP_BLANK
    } disp_mode_t;

    localparam logic [7:0] KEY_BREAK = 8'hF0;
    localparam logic [7:0] KEY_EXT   = 8'hE0;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam int BCD_MAX_DIGITS = 8;
    localparam int BCD_W          = 4 * BCD_MAX_DIGITS;

    // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 is blanked.
    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        logic [6:0] pattern;
        case (nibble)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

    // Packed BCD minus one: a zero nibble wraps to 9 and borrows from the next.
    function automatic logic [BCD_W-1:0] bcd_dec(input logic [BCD_W-1:0] value);
        logic [BCD_W-1:0] result;
        logic             borrow;
        result = value;
        borrow = 1'b1;
        for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
            if (borrow) begin
                if (value[4*i +: 4] == 4'd0) begin
                    result[4*i +: 4] = 4'd9;
                end else begin
                    result[4*i +: 4] = value[4*i +: 4] - 4'd1;
                    borrow           = 1'b0;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/seg_scan.sv
// Multiplexed 7-segment scanner: advances one digit every SCAN_DIV cycles and
// registers the active-low digit select and segment pattern together.
module seg_scan
    import bomb_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 4000
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [4*DIGITS-1:0] nibbles,
    input  disp_mode_t          mode,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   sel
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = $clog2(DIGITS);

    logic [DIV_W-1:0]  div_reg, div_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [6:0]        seg_reg, seg_next;
    logic [DIGITS-1:0] sel_reg, sel_next;
    logic [3:0]        digit [DIGITS];
    logic              step;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign digit[gi] = nibbles[4*gi +: 4];
        end
    endgenerate

    always_comb begin
        step     = (div_reg == DIV_W'(SCAN_DIV - 1));
        div_next = step ? '0 : div_reg + 1'b1;
        idx_next = idx_reg;
        seg_next = seg_reg;
        sel_next = sel_reg;
        if (step) begin
            // Index starts at the top digit so the first step lands on digit 0.
            idx_next = (idx_reg == IDX_W'(DIGITS - 1)) ? '0 : idx_reg + 1'b1;
            sel_next = ~(DIGITS'(1) << idx_next);
            case (mode)
                DISP_DIGIT: seg_next = seg_decode(digit[idx_next]);
                DISP_DASH:  seg_next = SEG_DASH;
                default:    seg_next = SEG_BLANK;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            div_reg <= '0;
            idx_reg <= IDX_W'(DIGITS - 1);
            seg_reg <= SEG_BLANK;
            sel_reg <= '1;
        end else begin
            div_reg <= div_next;
            idx_reg <= idx_next;
            seg_reg <= seg_next;
            sel_reg <= sel_next;
        end
    end

    assign seg = seg_reg;
    assign sel = sel_reg;

endmodule

// File: rtl/bomb_lock.sv
// Keyboard-defused countdown lock: filters PS/2 scan codes against a fixed code,
// counts wrong keys, runs a BCD seconds countdown and drives the scanned display.
module bomb_lock
    import bomb_pkg::*;
#(
    parameter int                    CODE_LEN      = 4,
    parameter logic [8*CODE_LEN-1:0] CODE          = {8'h2C, 8'h35, 8'h3A, 8'h4B},
    parameter int                    DIGITS        = 2,
    parameter logic [4*DIGITS-1:0]   START_BCD     = 'h30,
    parameter int                    TICKS_PER_SEC = 50_000_000,
    parameter int                    SCAN_DIV      = 4000,
    parameter int                    ERR_MAX       = 10
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                arm,
    input  logic                key_valid,
    input  logic [7:0]          key_data,
    output logic [CODE_LEN-1:0] led,
    output logic                armed,
    output logic                defused,
    output logic                exploded,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   sel
);

    localparam int IDX_W   = $clog2(CODE_LEN + 1);
    localparam int PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int TW      = 4 * DIGITS;

    state_t              state_reg, state_next;
    logic [TW-1:0]       timer_reg, timer_next;
    logic [BCD_W-1:0]    timer_wide;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [3:0]          err_reg, err_next;
    logic                skip_reg, skip_next;
    logic [CODE_LEN-1:0] led_reg, led_next;
    logic [PRESC_W-1:0]  presc_reg, presc_next;
    logic                tick;
    logic [7:0]          code_byte [CODE_LEN];
    logic [7:0]          expected_byte;
    disp_mode_t          disp_mode;

    // First key of the code sits in the most significant byte.
    genvar gi;
    generate
        for (gi = 0; gi < CODE_LEN; gi++) begin : g_code
            assign code_byte[gi] = CODE[8*(CODE_LEN-1-gi) +: 8];
        end
    endgenerate

    always_comb begin
        expected_byte = code_byte[0];
        for (int i = 1; i < CODE_LEN; i++) begin
            if (idx_reg == IDX_W'(i)) expected_byte = code_byte[i];
        end
    end

    // Upper nibbles stay zero while the timer is non-zero, so a full-width
    // compare of the widened result is a valid zero test.
    assign timer_wide = bcd_dec(BCD_W'(timer_reg));

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        idx_next   = idx_reg;
        err_next   = err_reg;
        skip_next  = skip_reg;
        led_next   = led_reg;
        presc_next = presc_reg;
        tick       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (arm) begin
                    state_next = ST_ARMED;
                    presc_next = '0;
                end
            end

            ST_ARMED: begin
                tick       = (presc_reg == PRESC_W'(TICKS_PER_SEC - 1));
                presc_next = tick ? '0 : presc_reg + 1'b1;
                if (tick) begin
                    timer_next = timer_wide[TW-1:0];
                    if (timer_wide == '0) state_next = ST_EXPLODED;
                end

                // Key handling follows the tick so a final code key overrides a zero tick.
                if (key_valid) begin
                    if (skip_reg) begin
                        skip_next = 1'b0;
                    end else if (key_data == KEY_BREAK) begin
                        skip_next = 1'b1;
                    end else if (key_data == KEY_EXT) begin
                        skip_next = skip_reg;
                    end else if (key_data == expected_byte) begin
                        led_next = led_reg | (CODE_LEN'(1) << idx_reg);
                        idx_next = idx_reg + 1'b1;
                        if (idx_reg == IDX_W'(CODE_LEN - 1)) state_next = ST_DEFUSED;
                    end else begin
                        idx_next = '0;
                        led_next = '0;
                        err_next = err_reg + 4'd1;
                        if (err_reg == 4'(ERR_MAX - 1)) state_next = ST_EXPLODED;
                    end
                end

                if (state_next != ST_ARMED) skip_next = 1'b0;
            end

            default: begin
                state_next = state_reg;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg <= ST_IDLE;
            timer_reg <= START_BCD;
            idx_reg   <= '0;
            err_reg   <= '0;
            skip_reg  <= 1'b0;
            led_reg   <= '0;
            presc_reg <= '0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            idx_reg   <= idx_next;
            err_reg   <= err_next;
            skip_reg  <= skip_next;
            led_reg   <= led_next;
            presc_reg <= presc_next;
        end
    end

    assign led       = led_reg;
    assign armed     = (state_reg == ST_ARMED);
    assign defused   = (state_reg == ST_DEFUSED);
    assign exploded  = (state_reg == ST_EXPLODED);
    assign disp_mode = (state_reg == ST_EXPLODED) ? DISP_DASH : DISP_DIGIT;

    seg_scan #(
        .DIGITS  (DIGITS),
        .SCAN_DIV(SCAN_DIV)
    ) u_seg_scan (
        .clk    (clk),
        .clr    (clr),
        .nibbles(timer_reg),
        .mode   (disp_mode),
        .seg    (seg),
        .sel    (sel)
    );

endmodule

// File: tb/tb_bomb_lock.sv
// Self-checking bench for bomb_lock: directed scenarios plus random soak against
// a seconds/cycle-count reference model of the lock, timer and display.
module tb_bomb_lock;

    localparam int CODE_LEN   = 4;
    localparam int DIGITS     = 2;
    localparam int TPS        = 10;
    localparam int SCAN_DIV   = 4;
    localparam int ERR_MAX    = 3;
    localparam int START_SECS = 3;
    localparam logic [31:0] CODE      = {8'h2C, 8'h35, 8'h3A, 8'h4B};
    localparam logic [7:0]  START_BCD = 8'h03;
    localparam logic [6:0]  DASH      = 7'b0111111;
    localparam logic [15:0] RESET_VEC = {4'b0000, 3'b000, 7'h7F, 2'b11};
    localparam int M_IDLE = 0, M_ARMED = 1, M_DEF = 2, M_EXPL = 3;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       arm = 1'b0;
    logic       key_valid = 1'b0;
    logic [7:0] key_data = 8'h00;
    logic [3:0] led;
    logic       armed, defused, exploded;
    logic [6:0] seg;
    logic [1:0] sel;

    int checks = 0;
    int errors = 0;

    bomb_lock #(
        .CODE_LEN     (CODE_LEN),
        .CODE         (CODE),
        .DIGITS       (DIGITS),
        .START_BCD    (START_BCD),
        .TICKS_PER_SEC(TPS),
        .SCAN_DIV     (SCAN_DIV),
        .ERR_MAX      (ERR_MAX)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .arm      (arm),
        .key_valid(key_valid),
        .key_data (key_data),
        .led      (led),
        .armed    (armed),
        .defused  (defused),
        .exploded (exploded),
        .seg      (seg),
        .sel      (sel)
    );

    always #5 clk = ~clk;

    // Reference model: progress index, wrong-key count, cycles spent armed.
    int         m_state, m_idx, m_err, m_cyc, m_scan;
    bit         m_skip;
    logic [6:0] m_seg;
    logic [1:0] m_sel;
    logic [7:0] code_q [CODE_LEN] = '{8'h2C, 8'h35, 8'h3A, 8'h4B};
    logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    function automatic int secs_left();
        return START_SECS - m_cyc / TPS;
    endfunction

    function automatic logic [15:0] expected();
        logic [3:0] l;
        l = 4'((1 << m_idx) - 1);
        return {l, m_state == M_ARMED, m_state == M_DEF, m_state == M_EXPL, m_seg, m_sel};
    endfunction

    task automatic model_reset();
        m_state = M_IDLE; m_idx = 0; m_err = 0; m_cyc = 0; m_scan = 0;
        m_skip = 0; m_seg = 7'h7F; m_sel = 2'b11;
    endtask

    task automatic model_step(input bit a, input bit kv, input logic [7:0] kd);
        int nxt, d, p;
        m_scan++;
        if (m_scan % SCAN_DIV == 0) begin
            d = (m_scan / SCAN_DIV - 1) % DIGITS;
            p = 1;
            for (int j = 0; j < d; j++) p = p * 10;
            m_sel = ~(2'b01 << d);
            m_seg = (m_state == M_EXPL) ? DASH : pat[(secs_left() / p) % 10];
        end
        if (m_state == M_IDLE) begin
            if (a) m_state = M_ARMED;
        end else if (m_state == M_ARMED) begin
            nxt = M_ARMED;
            m_cyc++;
            if (m_cyc % TPS == 0 && secs_left() == 0) nxt = M_EXPL;
            if (kv) begin
                if (m_skip) m_skip = 0;
                else if (kd == 8'hF0) m_skip = 1;
                else if (kd != 8'hE0) begin
                    if (kd == code_q[m_idx]) begin
                        m_idx++;
                        if (m_idx == CODE_LEN) nxt = M_DEF;
                    end else begin
                        m_idx = 0;
                        m_err++;
                        if (m_err == ERR_MAX) nxt = M_EXPL;
                    end
                end
            end
            m_state = nxt;
        end
    endtask

    task automatic step(input bit a, input bit kv, input logic [7:0] kd);
        arm = a; key_valid = kv; key_data = kd;
        @(posedge clk);
        model_step(a, kv, kd);
        #1;
        arm = 1'b0; key_valid = 1'b0;
    endtask

    task automatic do_reset();
        #2 clr = 1'b1;
        #2 clr = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        model_reset();
        #7;
        checks++;
        if ({led, armed, defused, exploded, seg, sel} !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_values got %h want %h", {led, armed, defused, exploded, seg, sel}, RESET_VEC);
        end
        clr = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 8'($urandom));
            checks++;
            if ({led, armed, defused, exploded, seg, sel} !== expected()) begin
                errors++;
                $display("FAIL reset_idle step %0d got %h want %h", i, {led, armed, defused, exploded, seg, sel}, expected());
            end
        end
        checks++;
        if ({seg, sel} !== {7'b0110000, 2'b10}) begin
            errors++;
            $display("FAIL reset_first_scan got seg %b sel %b want seg 0110000 sel 10", seg, sel);
        end
    endtask

    task automatic test_correct_sequence();
        do_reset();
        step(1, 0, 8'h00);
        for (int k = 0; k < CODE_LEN; k++) begin
            if ($urandom_range(0, 1) == 1) step(0, 0, 8'($urandom));
            step(0, 1, code_q[k]);
            checks++;
            if ({led, armed, defused, exploded, seg, sel} !== expected()) begin
                errors++;
                $display("FAIL seq_model key %0d got %h want %h", k, {led, armed, defused, exploded, seg, sel}, expected());
            end
            checks++;
            if (led !== 4'((1 << (k + 1)) - 1)) begin
                errors++;
                $display("FAIL seq_led key %0d got %b want %b", k, led, 4'((1 << (k + 1)) - 1));
            end
        end
        checks++;
        if (defused !== 1'b1) begin
            errors++;
            $display("FAIL seq_defused got %b want 1", defused);
        end
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 8'h00);
            checks++;
            if ({led, armed, defused, exploded, seg, sel} !== expected()) begin
                errors++;
                $display("FAIL seq_hold step %0d got %h want %h", i, {led, armed, defused, exploded, seg, sel}, expected());
            end
        end
        checks++;
        if (seg !== ((sel == 2'b10) ? 7'b0110000 : 7'b1000000)) begin
            errors++;
            $display("FAIL seq_frozen_03 sel %b got seg %b", sel, seg);
        end
    endtask

    task automatic test_break_filter();
        logic [7:0] seq [$];
        logic [3:0] led_before;
        seq = '{8'h2C, 8'hF0, 8'h2C};
        for (int k = 1; k < CODE_LEN; k++) begin
            if ($urandom_range(0, 1) == 1) seq.push_back(8'hE0);
            seq.push_back(code_q[k]);
        end
        do_reset();
        step(1, 0, 8'h00);
        foreach (seq[j]) begin
            led_before = led;
            step(0, 1, seq[j]);
            checks++;
            if ({led, armed, defused, exploded, seg, sel} !== expected()) begin
                errors++;
                $display("FAIL brk_model byte %0d (%h) got %h want %h", j, seq[j], {led, armed, defused, exploded, seg, sel}, expected());
            end
            if (seq[j] == 8'hE0 || j == 2) begin
                checks++;
                if (led !== led_before) begin
                    errors++;
                    $display("FAIL brk_dropped byte %0d got led %b want %b", j, led, led_before);
                end
            end
        end
        checks++;
        if ({defused, exploded, led} !== {2'b10, 4'b1111}) begin
            errors++;
            $display("FAIL brk_defused got %b%b led %b want defused 1 exploded 0 led 1111", defused, exploded, led);
        end
    endtask

    task automatic test_error_limit();
        logic [7:0] seq [4];
        seq = '{8'h2C, 8'h11, 8'h11, 8'h11};
        do_reset();
        step(1, 0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) step(0, 0, 8'h11);
            step(0, 1, seq[k]);
            checks++;
            if ({led, armed, defused, exploded, seg, sel} !== expected()) begin
                errors++;
                $display("FAIL err_model key %0d got %h want %h", k, {led, armed, defused, exploded, seg, sel}, expected());
            end
            checks++;
            if ({led, exploded} !== {((k == 0) ? 4'b0001 : 4'b0000), (k == 3)}) begin
                errors++;
                $display("FAIL err_progress key %0d got led %b exploded %b", k, led, exploded);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        step(1, 0, 8'h00);
        for (int i = 1; i <= 40; i++) begin
            step(0, 0, 8'($urandom));
            checks++;
            if ({led, armed, defused, exploded, seg, sel} !== expected()) begin
                errors++;
                $display("FAIL tmo_model cycle %0d got %h want %h", i, {led, armed, defused, exploded, seg, sel}, expected());
            end
            if (i == 29 || i == 30) begin
                checks++;
                if (exploded !== (i == 30)) begin
                    errors++;
                    $display("FAIL tmo_explode cycle %0d got %b want %b", i, exploded, (i == 30));
                end
            end
            if (i >= 38) begin
                checks++;
                if (seg !== DASH) begin
                    errors++;
                    $display("FAIL tmo_dash cycle %0d sel %b got %b want %b", i, sel, seg, DASH);
                end
            end
        end
    endtask

    task automatic test_priority();
        do_reset();
        step(1, 0, 8'h00);
        for (int i = 1; i <= 34; i++) begin
            case (i)
                3:       step(0, 1, code_q[0]);
                12:      step(0, 1, code_q[1]);
                21:      step(0, 1, code_q[2]);
                30:      step(0, 1, code_q[3]);
                default: step(0, 0, 8'h00);
            endcase
            checks++;
            if ({led, armed, defused, exploded, seg, sel} !== expected()) begin
                errors++;
                $display("FAIL prio_model cycle %0d got %h want %h", i, {led, armed, defused, exploded, seg, sel}, expected());
            end
        end
        checks++;
        if ({defused, exploded} !== 2'b10) begin
            errors++;
            $display("FAIL prio_defused got defused %b exploded %b want 1 0", defused, exploded);
        end
    endtask

    task automatic test_clr_mid_armed();
        do_reset();
        step(1, 0, 8'h00);
        step(0, 1, code_q[0]);
        step(0, 1, code_q[1]);
        for (int g = $urandom_range(3, 12); g > 0; g--) step(0, 0, 8'h00);
        clr = 1'b1;
        #2;
        checks++;
        if ({led, armed, defused, exploded, seg, sel} !== RESET_VEC) begin
            errors++;
            $display("FAIL clr_async got %h want %h", {led, armed, defused, exploded, seg, sel}, RESET_VEC);
        end
        clr = 1'b0;
        model_reset();
        for (int i = 1; i <= 12; i++) begin
            step(0, 1, code_q[2]);
            checks++;
            if ({led, armed, defused, exploded, seg, sel} !== expected()) begin
                errors++;
                $display("FAIL clr_after step %0d got %h want %h", i, {led, armed, defused, exploded, seg, sel}, expected());
            end
            if (i % 4 == 0) begin
                checks++;
                if (sel !== (((i / 4) % 2 == 1) ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL clr_scan_order step %0d got %b want %b", i, sel, (((i / 4) % 2 == 1) ? 2'b10 : 2'b01));
                end
            end
        end
    endtask

    task automatic test_random_soak();
        int         r;
        bit         a, kv;
        logic [7:0] kd;
        for (int run = 0; run < 8; run++) begin
            do_reset();
            for (int i = 0; i < 60; i++) begin
                r  = $urandom_range(0, 9);
                kd = (r < 4) ? code_q[r] : (r == 4) ? 8'hF0 : (r == 5) ? 8'hE0 : 8'($urandom);
                kv = ($urandom_range(0, 2) == 0);
                a  = ($urandom_range(0, 3) == 0);
                step(a, kv, kd);
                checks++;
                if ({led, armed, defused, exploded, seg, sel} !== expected()) begin
                    errors++;
                    $display("FAIL soak run %0d step %0d arm %b kv %b kd %h got %h want %h",
                             run, i, a, kv, kd, {led, armed, defused, exploded, seg, sel}, expected());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_correct_sequence();
        test_break_filter();
        test_error_limit();
        test_timeout();
        test_priority();
        test_clr_mid_armed();
        test_random_soak();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bomb_lock.md
# bomb_lock

Parametrised keyboard-defused countdown lock. It consumes decoded PS/2 scan-code bytes from the upstream receiver and matches them against a CODE_LEN-key defuse code, with break-code filtering and an error limit. It runs a BCD seconds countdown and drives a multiplexed active-low 7-segment display plus progress LEDs. It sits between the PS/2 byte receiver and the board I/O.

## Interface
- CODE_LEN, 4: number of keys in the defuse code (1..8).
- CODE, {8'h2C,8'h35,8'h3A,8'h4B}: flat 8*CODE_LEN make-codes; the first key is in the most significant byte.
- DIGITS, 2: BCD display digits (2..8).
- START_BCD, 'h30: initial countdown, 4*DIGITS bits, each nibble 0..9.
- TICKS_PER_SEC, 50_000_000: clk cycles per second.
- SCAN_DIV, 4000: clk cycles per display digit step.
- ERR_MAX, 10: wrong-key count that detonates (1..15).
- clk  in  1  system clock.
- clr  in  1  asynchronous active-high reset.
- arm  in  1  level-sampled start request.
- key_valid  in  1  single-cycle strobe qualifying key_data.
- key_data  in  8  scan-code byte.
- led  out  CODE_LEN  thermometer defuse progress; bit i set once key i has matched.
- armed, defused, exploded  out  1 each  one-hot status; all 0 in IDLE.
- seg  out  7  active-low segments {g,f,e,d,c,b,a}.
- sel  out  DIGITS  active-low one-hot digit select; bit 0 is the least significant digit.

## Operation
- Reset values: state IDLE, timer=START_BCD, idx=0, err=0, skip=0, led=0, armed/defused/exploded=0, seg=7'h7F, sel=all ones, scan index=DIGITS-1.
- FSM states: IDLE, ARMED, DEFUSED, EXPLODED.
  - IDLE→ARMED when arm=1. The prescaler clears at this transition.
  - DEFUSED and EXPLODED are terminal; only clr leaves them. arm is ignored outside IDLE.
- Key filter, applied only when key_valid=1 in ARMED:
  - 8'hF0 sets skip.
  - The next byte after F0 is dropped and clears skip.
  - 8'hE0 is dropped with no other effect.
  - Any other byte is a make-code.
- Make-code equal to CODE byte idx:
  - led[idx]←1, idx+1.
  - If idx+1=CODE_LEN, go to DEFUSED.
- Any other make-code:
  - idx←0, led←0, err+1.
  - If err+1=ERR_MAX, go to EXPLODED.
  - No partial re-match.
- Keys are ignored outside ARMED. skip clears on leaving ARMED.
- Timer:
  - The prescaler counts 0..TICKS_PER_SEC-1 in ARMED only; tick fires at terminal count.
  - Tick performs a BCD decrement: a nibble at 0 becomes 9 and borrows from the next nibble.
  - If the decremented value is 0, go to EXPLODED.
  - The timer freezes in DEFUSED and EXPLODED.
- Simultaneous events: if the final code key and the zero-reaching tick occur in the same cycle, DEFUSED wins. A wrong key that hits ERR_MAX together with a tick both lead to EXPLODED.
- Display:
  - The scan index advances (wrapping DIGITS-1→0) every SCAN_DIV cycles.
  - Each step registers sel and seg together.
  - IDLE, ARMED and DEFUSED show the timer nibble for the selected digit using standard 0-9 active-low patterns (0=7'b1000000, 9=7'b0010000).
  - EXPLODED shows dash 7'b0111111 on every digit.

## Timing
- key_valid → led/status update: 1 cycle (registered).
- First decrement occurs exactly TICKS_PER_SEC cycles after the cycle arm is sampled; later decrements follow every TICKS_PER_SEC cycles.
- A timer change is visible on seg at the next scan step for that digit; worst case is DIGITS*SCAN_DIV cycles.
- The first scan step lands SCAN_DIV cycles after clr deasserts and selects digit 0.
- clr mid-operation returns everything to reset values immediately (asynchronous); no pending key or tick survives.

## Structure
- Package bomb_pkg holds:
  - the state enum;
  - the constants KEY_BREAK=8'hF0, KEY_EXT=8'hE0, SEG_BLANK=7'h7F, SEG_DASH=7'b0111111;
  - function seg_decode(nibble), and function bcd_dec(vector).
- One sub-module, seg_scan (parameters DIGITS, SCAN_DIV), contains the scan divider and index and the sel/seg registers. It is fed digit nibbles and a blank/dash mode.
- The FSM, key filter, prescaler and BCD timer stay in bomb_lock.

## Test plan
All scenarios use CODE_LEN=4, DIGITS=2, START_BCD='h03, TICKS_PER_SEC=10, SCAN_DIV=4, ERR_MAX=3.
- Correct sequence: arm, then 2C,35,3A,4B → led 0001→0011→0111→1111, with each update 1 cycle after its strobe; defused=1 and the timer is frozen at 'h03.
- Break filtering: arm, then 2C,F0,2C,35,3A,4B → the 2C after F0 is ignored; the bench ends with defused=1 and err=0. Sending E0 mid-sequence leaves idx unchanged.
- Timeout: arm with no keys → timer reads 02 after 10 cycles, 01 after 20 and 00 after 30; exploded=1 at cycle 30 and both digits show 7'b0111111.
- Error limit: arm, then 2C, 11, 11, 11 → led clears to 0 on the first 11; exploded=1 one cycle after the third wrong key.
- Priority and reset: place 4B as the final key on the same cycle as the zero tick → defused=1. Then pulse clr mid-ARMED in a separate run → all outputs return to reset values the same cycle, and the bench checks the scan order (sel 10, 01, 10...) every 4 cycles.
